// File: rtl/heu.sv
// Histogram equalization unit: captures a 5x80 byte window, builds a 256-bin
// histogram, converts it in place to a CDF and remaps every pixel through it.
module heu (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       vldIpgu,
  input  logic [4:0][79:0][7:0]      ipguOutBufferQ,
  output logic                       rdyHeu,
  output logic                       vldHeu,
  output logic [4:0][79:0][7:0]      heuOutBufferQ,
  input  logic                       rdyRnn
);

  localparam int unsigned NUM_PIX     = 400;
  localparam int unsigned PIX_W       = 8;
  localparam int unsigned BINS        = 256;
  localparam int unsigned BIN_W       = 9;
  localparam int unsigned CNT_W       = 9;
  localparam int unsigned PROD_W      = 19;
  localparam int unsigned SCALE_MUL   = 653;
  localparam int unsigned SCALE_SHIFT = 10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HIST = 3'd1,
    S_CDF  = 3'd2,
    S_MAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [NUM_PIX-1:0][PIX_W-1:0] r_in;
  logic [NUM_PIX-1:0][PIX_W-1:0] r_out;
  logic [BIN_W-1:0]              r_hist [BINS];
  logic [CNT_W-1:0]              r_cnt;
  logic [PIX_W-1:0]              r_bin;
  logic [BIN_W-1:0]              r_acc;
  logic                          r_vld;

  logic                          w_accept;
  logic                          w_cnt_last;
  logic                          w_bin_last;
  logic [PIX_W-1:0]              w_pix;
  logic [BIN_W-1:0]              w_acc_sum;
  logic [PROD_W-1:0]             w_prod;
  logic [PIX_W-1:0]              w_map;

  assign w_accept   = vldIpgu && (r_state == S_IDLE);
  assign w_cnt_last = (r_cnt == CNT_W'(NUM_PIX - 1));
  assign w_bin_last = (r_bin == PIX_W'(BINS - 1));
  assign w_pix      = r_in[r_cnt];
  assign w_acc_sum  = r_acc + r_hist[r_bin];
  // Scaled CDF lookup; cdf<=400 keeps the shifted result within 8 bits.
  assign w_prod     = PROD_W'(r_hist[w_pix]) * PROD_W'(SCALE_MUL);
  assign w_map      = PIX_W'(w_prod >> SCALE_SHIFT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_state_nxt = S_HIST;
      S_HIST:  if (w_cnt_last) w_state_nxt = S_CDF;
      S_CDF:   if (w_bin_last) w_state_nxt = S_MAP;
      S_MAP:   if (w_cnt_last) w_state_nxt = S_DONE;
      S_DONE:  if (rdyRnn)     w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    rdyHeu = 1'b0;
    if (r_state == S_IDLE) rdyHeu = 1'b1;
  end

  // Datapath: capture, histogram, in-place CDF and remap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in  <= '0;
      r_out <= '0;
      r_cnt <= '0;
      r_bin <= '0;
      r_acc <= '0;
      r_vld <= 1'b0;
      for (int i = 0; i < BINS; i++) r_hist[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_in  <= ipguOutBufferQ;
            r_cnt <= '0;
            for (int i = 0; i < BINS; i++) r_hist[i] <= '0;
          end
        end
        S_HIST: begin
          r_hist[w_pix] <= r_hist[w_pix] + BIN_W'(1);
          if (w_cnt_last) begin
            r_cnt <= '0;
            r_bin <= '0;
            r_acc <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_CDF: begin
          r_acc         <= w_acc_sum;
          r_hist[r_bin] <= w_acc_sum;
          r_bin         <= r_bin + PIX_W'(1);
        end
        S_MAP: begin
          r_out[r_cnt] <= w_map;
          if (w_cnt_last) begin
            r_cnt <= '0;
            r_vld <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (rdyRnn) r_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign vldHeu        = r_vld;
  assign heuOutBufferQ = r_out;

endmodule

// File: tb/tb_heu.sv
// Bench for heu: directed and random windows checked against a histogram/CDF
// reference model, plus latency, back-pressure, reset and throughput checks.
module tb_heu;

  localparam int NUM_PIX = 400;
  localparam int PERIOD  = 10;

  logic                  clk;
  logic                  rst_n;
  logic                  vldIpgu;
  logic [4:0][79:0][7:0] ipguOutBufferQ;
  logic                  rdyHeu;
  logic                  vldHeu;
  logic [4:0][79:0][7:0] heuOutBufferQ;
  logic                  rdyRnn;

  int   checks = 0;
  int   errors = 0;
  logic [7:0] pix   [NUM_PIX];
  logic [7:0] exp_b [NUM_PIX];
  time  t_acc;

  heu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vldIpgu        (vldIpgu),
    .ipguOutBufferQ (ipguOutBufferQ),
    .rdyHeu         (rdyHeu),
    .vldHeu         (vldHeu),
    .heuOutBufferQ  (heuOutBufferQ),
    .rdyRnn         (rdyRnn)
  );

  initial begin
    clk = 1'b0;
    forever #(PERIOD/2) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Reference: count values, prefix-sum, scale by 653/1024.
  task automatic build_expected();
    int h [256];
    int c [256];
    int run;
    for (int b = 0; b < 256; b++) h[b] = 0;
    for (int i = 0; i < NUM_PIX; i++) h[pix[i]]++;
    run = 0;
    for (int b = 0; b < 256; b++) begin
      run += h[b];
      c[b] = run;
    end
    for (int i = 0; i < NUM_PIX; i++) exp_b[i] = 8'((c[pix[i]] * 653) / 1024);
  endtask

  task automatic drive_pix();
    for (int i = 0; i < NUM_PIX; i++) ipguOutBufferQ[i/80][i%80] = pix[i];
  endtask

  task automatic check_out(input string tag);
    int nbad = 0;
    int first = 0;
    for (int i = 0; i < NUM_PIX; i++) begin
      if (heuOutBufferQ[i/80][i%80] !== exp_b[i]) begin
        if (nbad == 0) first = i;
        nbad++;
      end
    end
    checks++;
    assert (nbad == 0) else begin
      errors++;
      $error("FAIL %s: %0d bad bytes, first idx %0d got %02h expected %02h",
             tag, nbad, first, heuOutBufferQ[first/80][first%80], exp_b[first]);
    end
  endtask

  // Entered at #1 after an edge; presents pix and returns after the accept edge.
  task automatic accept_window(output int waited);
    waited = 0;
    drive_pix();
    vldIpgu = 1'b1;
    while (!rdyHeu && waited < 3000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("accept_timeout", 32'(rdyHeu), 32'd1);
    @(posedge clk);
    t_acc = $time;
    #1;
    vldIpgu = 1'b0;
    for (int i = 0; i < NUM_PIX; i++) ipguOutBufferQ[i/80][i%80] = 8'($urandom);
    chk("rdy_drop", 32'(rdyHeu), 32'd0);
  endtask

  task automatic wait_vld(input string tag);
    int lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!vldHeu && lat < 2000);
    chk(tag, 32'(lat), 32'd1056);
  endtask

  task automatic handshake();
    rdyRnn = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_vld", 32'(vldHeu), 32'd0);
    chk("hs_rdy", 32'(rdyHeu), 32'd1);
    rdyRnn = 1'b0;
  endtask

  task automatic run_window(input string tag);
    int w;
    build_expected();
    accept_window(w);
    wait_vld({tag, "_lat"});
    check_out(tag);
    handshake();
  endtask

  initial begin
    int w;
    time t1;
    rst_n = 1'b0;
    vldIpgu = 1'b0;
    rdyRnn = 1'b0;
    ipguOutBufferQ = '0;
    #3;
    chk("rst_rdy", 32'(rdyHeu), 32'd1);
    chk("rst_vld", 32'(vldHeu), 32'd0);
    checks++;
    assert (heuOutBufferQ === '0) else begin
      errors++;
      $error("FAIL rst_out: got nonzero expected zero");
    end
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NUM_PIX; i++) pix[i] = 8'h80;
    run_window("const80");
    for (int i = 0; i < NUM_PIX; i++) pix[i] = (i < 200) ? 8'h00 : 8'hFF;
    run_window("half");
    for (int i = 0; i < NUM_PIX; i++) pix[i] = 8'(i % 4);
    run_window("mod4");
    for (int i = 0; i < NUM_PIX; i++) pix[i] = 8'($urandom);
    run_window("rand_full");
    for (int i = 0; i < NUM_PIX; i++) pix[i] = 8'($urandom_range(0, 7));
    run_window("rand_small");

    // Back-pressure with a new window waiting upstream.
    for (int i = 0; i < NUM_PIX; i++) pix[i] = 8'($urandom_range(10, 40));
    build_expected();
    accept_window(w);
    wait_vld("bp_lat");
    for (int i = 0; i < NUM_PIX; i++) pix[i] = 8'($urandom);
    drive_pix();
    vldIpgu = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      chk("bp_vld", 32'(vldHeu), 32'd1);
      chk("bp_rdy", 32'(rdyHeu), 32'd0);
      check_out("bp_hold");
    end
    rdyRnn = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_rel_vld", 32'(vldHeu), 32'd0);
    chk("bp_rel_rdy", 32'(rdyHeu), 32'd1);
    rdyRnn = 1'b0;
    build_expected();
    accept_window(w);
    chk("bp_next_accept", 32'(w), 32'd0);
    wait_vld("bp_next_lat");
    check_out("bp_next");
    handshake();

    // Reset in the middle of MAP.
    for (int i = 0; i < NUM_PIX; i++) pix[i] = 8'($urandom);
    accept_window(w);
    repeat (799) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_vld", 32'(vldHeu), 32'd0);
    chk("mrst_rdy", 32'(rdyHeu), 32'd1);
    checks++;
    assert (heuOutBufferQ === '0) else begin
      errors++;
      $error("FAIL mrst_out: got nonzero expected zero");
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_PIX; i++) pix[i] = 8'h10;
    run_window("post_rst");

    // Back-to-back windows with rdyRnn tied high.
    rdyRnn = 1'b1;
    for (int i = 0; i < NUM_PIX; i++) pix[i] = 8'($urandom_range(0, 63));
    build_expected();
    accept_window(w);
    t1 = t_acc;
    wait_vld("b2b_a_lat");
    check_out("b2b_a");
    for (int i = 0; i < NUM_PIX; i++) pix[i] = 8'($urandom);
    build_expected();
    accept_window(w);
    chk("b2b_period", 32'((t_acc - t1) / PERIOD), 32'd1058);
    wait_vld("b2b_b_lat");
    check_out("b2b_b");
    @(posedge clk);
    #1;
    chk("b2b_vld_fall", 32'(vldHeu), 32'd0);
    check_out("b2b_b_kept");
    rdyRnn = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/heu.md
# heu

Histogram equalization unit: accepts one 400-pixel window (5×80 bytes) from the image pyramid generation unit over a valid/ready handshake. It builds a 256-bin histogram and its cumulative distribution, then remaps every pixel through a fixed-point scaled CDF. It presents the equalized window to the downstream neural-network stage over a second valid/ready handshake. It sits between the IPGU and the RNN input stage and processes one window at a time.

## Interface
- NUM_PIX, 400: pixels per window; fixed at 5×80.
- SCALE_MUL, 653: CDF scale multiplier.
- SCALE_SHIFT, 10: right shift applied after the multiply. (653/1024 ≈ 255/400.)

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- vldIpgu  in  1  the input window is valid.
- ipguOutBufferQ  in  [7:0] [4:0][79:0]  input window; pixel index i = r*80+c for element [r][c].
- rdyHeu  out  1  HEU can accept a window; high only in IDLE.
- vldHeu  out  1  output window valid; registered.
- heuOutBufferQ  out  [7:0] [4:0][79:0]  equalized window, same pixel ordering as the input; registered.
- rdyRnn  in  1  the downstream stage accepts the output window.

## Operation
- States are IDLE → HIST → CDF → MAP → DONE → IDLE.
- IDLE:
  - rdyHeu=1.
  - On vldIpgu&rdyHeu: capture all 400 bytes into an input register, clear all 256 histogram bins (9 bits each) to 0, clear the pixel counter, then go to HIST.
- HIST, 400 cycles: each cycle, hist[in[cnt]] += 1 and cnt++. On cnt==399, clear cnt and go to CDF.
- CDF, 256 cycles:
  - The running sum acc (9 bits) starts at 0.
  - Each cycle: acc += hist[b], then hist[b] ← acc (in place, inclusive CDF), then b++.
  - On b==255, go to MAP.
  - cdf[255] always equals 400; bins never overflow (max 400 < 512).
- MAP, 400 cycles:
  - Each cycle: out[cnt] ← (cdf[in[cnt]] × SCALE_MUL) >> SCALE_SHIFT.
  - The product needs 19 bits unsigned. Take the low 8 bits of the shifted result; the maximum is (400×653)>>10 = 255, so no saturation is needed.
  - On cnt==399, go to DONE.
- DONE:
  - vldHeu=1. heuOutBufferQ is held stable.
  - On vldHeu&rdyRnn (same edge): vldHeu←0, go to IDLE.
  - heuOutBufferQ keeps its last value after the handshake; it is only overwritten in the next MAP.
- vldIpgu while not in IDLE is ignored; the upstream stage holds its data because rdyHeu=0.
- Input data is sampled only on the accepting edge. Changes to ipguOutBufferQ afterwards have no effect.

## Timing
- Reset (asynchronous, any state, mid-window included):
  - state=IDLE, rdyHeu=1, vldHeu=0.
  - heuOutBufferQ all 0x00; counters and histogram 0.
  - Any in-flight window is discarded.
- rdyHeu is decoded combinationally from state==IDLE. It drops in the cycle after the accept edge.
- Latency, with the accept edge as edge 0:
  - HIST occupies edges 1–400.
  - CDF occupies edges 401–656.
  - MAP occupies edges 657–1056.
  - vldHeu is high after edge 1056.
- Minimum period between accepted windows is 1058 cycles: accept, 1056 processing edges, then the DONE handshake edge. The next window is accepted at the earliest 1 cycle after the DONE handshake.
- Back-pressure: rdyRnn low in DONE holds the block indefinitely. vldHeu and the output data stay constant. rdyHeu stays 0.
- rdyRnn high before DONE has no effect.

## Test plan
- Constant image, all 400 pixels 0x80 → cdf[0x80]=400; every output byte is 0xFF. vldHeu rises exactly 1056 edges after the accept.
- 200 pixels 0x00 (indices 0–199) and 200 pixels 0xFF → outputs 0x7F (200×653>>10 = 127) for indices 0–199 and 0xFF for 200–399.
- Pixel i = i mod 4 (100 of each value 0–3) → value 0→0x3F, 1→0x7F, 2→0xBF, 3→0xFF.
- Hold rdyRnn=0 for 50 cycles in DONE, with vldIpgu high and new data presented → vldHeu and data stay stable, rdyHeu=0. Release rdyRnn → vldHeu falls on that edge, rdyHeu=1 on the next cycle, and the new window is accepted.
- Assert rst_n=0 during MAP (edge 800) → vldHeu=0, rdyHeu=1, output 0x00 immediately. A following window (all 0x10) produces all 0xFF with the full 1056-edge latency.
- Two back-to-back windows with rdyRnn tied high → the second accept occurs exactly 1058 cycles after the first, and both results are correct.
